// File: rtl/addsub_seq_if.sv
// Handshake and data bundle for addsub_seq.
// Valid/ready semantics on both sides: a transfer happens on a rising edge
// where valid and ready are both 1; the sender holds its payload stable while
// valid is 1 and ready is 0, and valid never waits on ready.
// master = operand source / result consumer, slave = addsub_seq.
interface addsub_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_1;
    logic [WIDTH-1:0] input_2;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] total;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, input_1, input_2, mode, out_ready,
        input  in_ready, out_valid, total, carry, overflow
    );

    modport slave (
        input  in_valid, input_1, input_2, mode, out_ready,
        output in_ready, out_valid, total, carry, overflow
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per
// clock, LSB slice first, carry chained through a register between slices.
// Subtraction is A + ~B + 1 (B inverted and carry seeded with 1 on accept).
// Optional feature: define ADDSUB_SAT_EN to clamp total on signed overflow.
// dbg_state exposes the FSM state (0=IDLE, 1=CALC, 2=DONE).
module addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_seq_if.slave  bus,
    output logic [1:0]   dbg_state
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] total_q, total_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CHUNK:0]   slice_sum;

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            total_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            total_q <= total_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    // Next-state and slice arithmetic: one CHUNK-bit slice per CALC cycle.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        total_d   = total_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        k_d       = k_q;
        slice_sum = {1'b0, a_q[int'(k_q)*CHUNK +: CHUNK]}
                  + {1'b0, b_q[int'(k_q)*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.input_1;
                    b_d     = bus.mode ? bus.input_2 : ~bus.input_2;
                    carry_d = ~bus.mode;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                total_d[int'(k_q)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                carry_d = slice_sum[CHUNK];
                if (k_q == K_LAST) begin
                    // Signed overflow: operands agree in sign, result does not.
                    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (total_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
                    if (ovf_d) begin
                        total_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`else
`endif
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.total     = total_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign dbg_state     = state_q;
endmodule
